orde_resp_arb: RTL and testbench

Round-robin arbiter that shares the single ordering-buffer write port among NUM_REQ per-channel read-response sources. It picks one source per cycle and loads the winner into a one-entry output register. The register drives the buffer's packet/type/channel/valid inputs and drains on the buffer's ready. A per-owner burst lock lets a source send up to MAX_BURST back-to-back packets before priority rotates.

---
 rtl/orde_resp_arb.sv | 138 +++++++++++++
 tb/tb_orde_resp_arb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/orde_resp_arb.sv
// Round-robin arbiter feeding the ordering-buffer write port from NUM_REQ response sources.
// One-entry full-throughput output register; per-owner burst lock of up to MAX_BURST beats.
module orde_resp_arb #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 32,
  parameter int RD_W      = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]    req_pkt,
  input  logic [NUM_REQ-1:0][RD_W-1:0]      req_rd_type,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              orde_rdy,
  output logic [DATA_W-1:0]                 out_pkt,
  output logic [RD_W-1:0]                   out_rd_type,
  output logic [$clog2(NUM_REQ)-1:0]        out_ch_addr,
  output logic                              out_valid,
  output logic [31:0]                       xfer_cnt
);

  localparam int CH_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [CH_W-1:0]  CH_MAX   = CH_W'(NUM_REQ - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t              r_state, w_state_nxt;
  logic [CH_W-1:0]     r_owner, r_rr_ptr;
  logic [CNT_W-1:0]    r_burst_cnt;
  logic [DATA_W-1:0]   r_out_pkt;
  logic [RD_W-1:0]     r_out_rd_type;
  logic [CH_W-1:0]     r_out_ch;
  logic                r_out_valid;
  logic [31:0]         r_xfer_cnt;

  logic [NUM_REQ-1:0]  w_grant;
  logic [CH_W-1:0]     w_gnt_idx;
  logic                w_any;
  logic                w_lock;
  logic                w_load_en;
  logic                w_xfer;

  assign w_load_en = !r_out_valid || orde_rdy;
  assign w_xfer    = w_load_en && w_any;
  assign w_lock    = (r_state == S_BURST) && req_valid[r_owner] && (r_burst_cnt < CNT_LAST);

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next state; the burst lock releases as soon as the last locked beat is granted
  always_comb begin
    w_state_nxt = r_state;
    if (w_xfer) begin
      if (r_state == S_IDLE)
        w_state_nxt = (MAX_BURST > 1) ? S_BURST : S_IDLE;
      else if (w_lock && (r_burst_cnt + CNT_W'(1) == CNT_LAST))
        w_state_nxt = S_IDLE;
      else
        w_state_nxt = S_BURST;
    end else if (w_load_en && (r_state == S_BURST)) begin
      w_state_nxt = S_IDLE;
    end
  end

  // FSM outputs: one-hot grant, burst owner first, else round-robin from r_rr_ptr
  always_comb begin
    int idx;
    idx       = 0;
    w_grant   = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    if (w_lock) begin
      w_grant[r_owner] = 1'b1;
      w_gnt_idx        = r_owner;
      w_any            = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(r_rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!w_any && req_valid[CH_W'(idx)]) begin
          w_any                = 1'b1;
          w_gnt_idx            = CH_W'(idx);
          w_grant[CH_W'(idx)]  = 1'b1;
        end
      end
    end
  end

  assign req_ready = w_load_en ? w_grant : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner     <= '0;
      r_rr_ptr    <= '0;
      r_burst_cnt <= '0;
    end else if (w_xfer) begin
      if (w_lock) begin
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
      end else begin
        r_owner     <= w_gnt_idx;
        r_burst_cnt <= '0;
        r_rr_ptr    <= (w_gnt_idx == CH_MAX) ? '0 : w_gnt_idx + CH_W'(1);
      end
    end
  end

  // Output register stage: loads whenever empty or draining this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid   <= 1'b0;
      r_out_pkt     <= '0;
      r_out_rd_type <= '0;
      r_out_ch      <= '0;
      r_xfer_cnt    <= '0;
    end else if (w_load_en) begin
      r_out_valid <= w_any;
      if (w_any) begin
        r_out_pkt     <= req_pkt[w_gnt_idx];
        r_out_rd_type <= req_rd_type[w_gnt_idx];
        r_out_ch      <= w_gnt_idx;
        r_xfer_cnt    <= r_xfer_cnt + 32'd1;
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pkt     = r_out_pkt;
  assign out_rd_type = r_out_rd_type;
  assign out_ch_addr = r_out_ch;
  assign xfer_cnt    = r_xfer_cnt;

endmodule

// File: tb/tb_orde_resp_arb.sv
// Directed bench for orde_resp_arb: NUM_REQ=4 with MAX_BURST=2 and a MAX_BURST=1 instance.
module tb_orde_resp_arb;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        valid, v1;
  logic [3:0][31:0]  pkt;
  logic [3:0][1:0]   rdt;
  logic              rdy;

  logic [3:0]        ready, ready1;
  logic [31:0]       opkt, opkt1;
  logic [1:0]        ordt, ordt1;
  logic [1:0]        och, och1;
  logic              ovld, ovld1;
  logic [31:0]       xcnt, xcnt1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  orde_resp_arb #(.NUM_REQ(4), .MAX_BURST(2), .DATA_W(32), .RD_W(2)) u_dut (
    .clk(clk), .rst(rst), .req_valid(valid), .req_pkt(pkt), .req_rd_type(rdt),
    .req_ready(ready), .orde_rdy(rdy), .out_pkt(opkt), .out_rd_type(ordt),
    .out_ch_addr(och), .out_valid(ovld), .xfer_cnt(xcnt)
  );

  orde_resp_arb #(.NUM_REQ(4), .MAX_BURST(1), .DATA_W(32), .RD_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_pkt(pkt), .req_rd_type(rdt),
    .req_ready(ready1), .orde_rdy(rdy), .out_pkt(opkt1), .out_rd_type(ordt1),
    .out_ch_addr(och1), .out_valid(ovld1), .xfer_cnt(xcnt1)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int seq2[8] = '{0, 0, 1, 1, 2, 2, 3, 3};
    int seq5[4] = '{0, 3, 0, 3};
    for (int i = 0; i < 4; i++) begin
      pkt[i] = 32'hA000_0000 + 32'(i);
      rdt[i] = 2'(i);
    end
    valid = '0; v1 = '0; rdy = 1'b1; rst = 1'b1;
    step(); step();
    chk("rst_vld", ovld, 0);
    chk("rst_xcnt", xcnt, 0);
    chk("rst_ch", och, 0);
    chk("rst_pkt", opkt, 0);
    rst = 1'b0;

    // single request
    valid = 4'b0100; #1;
    chk("t1_rdy", ready, 4'b0100);
    step();
    chk("t1_vld", ovld, 1);
    chk("t1_ch", och, 2);
    chk("t1_pkt", opkt, 32'hA000_0002);
    chk("t1_rdt", ordt, 2);
    chk("t1_xcnt", xcnt, 1);
    valid = '0;
    step();
    chk("t1_drain_vld", ovld, 0);
    chk("t1_drain_xcnt", xcnt, 1);

    // all valid, burst of two per channel, no bubbles
    do_reset();
    valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("t2_rdy", ready, 32'(1 << seq2[k]));
      step();
      chk("t2_ch", och, seq2[k]);
      chk("t2_vld", ovld, 1);
      chk("t2_xcnt", xcnt, k + 1);
    end

    // backpressure holds everything
    do_reset();
    valid = 4'hF;
    step();
    chk("t3_first_ch", och, 0);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t3_rdy_hold", ready, 0);
      step();
      chk("t3_ch_hold", och, 0);
      chk("t3_vld_hold", ovld, 1);
      chk("t3_xcnt_hold", xcnt, 1);
    end
    rdy = 1'b1; #1;
    chk("t3_resume_rdy", ready, 4'b0001);
    step();
    chk("t3_resume_ch", och, 0);
    chk("t3_resume_xcnt", xcnt, 2);
    #1;
    chk("t3_next_rdy", ready, 4'b0010);

    // owner drops mid-burst
    do_reset();
    valid = 4'b0010;
    step();
    chk("t4_ch1", och, 1);
    valid = 4'b1000; #1;
    chk("t4_rdy3", ready, 4'b1000);
    step();
    chk("t4_ch3", och, 3);
    chk("t4_xcnt", xcnt, 2);
    valid = 4'b1001; #1;
    chk("t4_owner3", ready, 4'b1000);
    step();
    #1;
    chk("t4_rr0", ready, 4'b0001);
    valid = '0;

    // MAX_BURST=1 alternation
    do_reset();
    v1 = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t5_ch", och1, seq5[k]);
      chk("t5_xcnt", xcnt1, k + 1);
    end
    v1 = '0;

    // reset while holding a packet in BURST
    do_reset();
    valid = 4'hF;
    step(); step(); step();
    chk("t6_pre_ch", och, 1);
    rst = 1'b1; #1;
    chk("t6_rst_vld", ovld, 0);
    chk("t6_rst_xcnt", xcnt, 0);
    step();
    rst = 1'b0;
    valid = 4'b1001; #1;
    chk("t6_rdy", ready, 4'b0001);
    step();
    chk("t6_ch", och, 0);
    chk("t6_xcnt", xcnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
